// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, aluop, mux-select constants and main-control state enum
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_OR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_RT = 2'b00;
  localparam logic [1:0] SRCB_4 = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_RWB, S_BRANCH, S_JUMP, S_IEXEC, S_IWB
  } state_t;
endpackage

// File: rtl/mc_main_ctrl_if.sv
// mc_main_ctrl_if: op/mem_ready into the controller; datapath enables, selects, aluop/rtype, exc, state_o out of it
interface mc_main_ctrl_if;
  logic [5:0] op;
  logic mem_ready;
  logic pcwrite;
  logic pcwritecond;
  logic iord;
  logic memread;
  logic memwrite;
  logic irwrite;
  logic memtoreg;
  logic regdst;
  logic regwrite;
  logic alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic [2:0] aluop;
  logic rtype;
  logic exc;
  logic [3:0] state_o;
  modport master (
    input op, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
      regwrite, alusrca, alusrcb, pcsource, aluop, rtype, exc, state_o
  );
  modport slave (
    output op, mem_ready,
    input pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
      regwrite, alusrca, alusrcb, pcsource, aluop, rtype, exc, state_o
  );
endinterface

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multicycle MIPS main control FSM; clk, rst_n (async low), bus.master carries op/mem_ready in and all datapath controls, aluop/rtype, exc, state_o out
module mc_main_ctrl
  import mips_pkg::*;
#(
  parameter bit EXC_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  mc_main_ctrl_if.master bus
);
  state_t state, nxt;
  logic legal;
  assign legal = bus.op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};
  assign bus.state_o = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (bus.op)
          OP_RTYPE: nxt = S_EXEC;
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_BEQ: nxt = S_BRANCH;
          OP_J: nxt = S_JUMP;
          OP_ADDI, OP_ORI: nxt = S_IEXEC;
          default: nxt = S_FETCH;
        endcase
      S_MEMADR: nxt = bus.op == OP_SW ? S_MEMWR : S_MEMRD;
      S_MEMRD: nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC: nxt = S_RWB;
      S_IEXEC: nxt = S_IWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: nxt = S_FETCH;
      default: nxt = S_IDLE;
    endcase
  end
  always_comb begin
    bus.pcwrite = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.iord = 1'b0;
    bus.memread = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst = 1'b0;
    bus.regwrite = 1'b0;
    bus.alusrca = 1'b0;
    bus.alusrcb = SRCB_RT;
    bus.pcsource = PCS_ALU;
    bus.aluop = 3'b000;
    bus.rtype = 1'b0;
    bus.exc = 1'b0;
    case (state)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = SRCB_4;
        bus.aluop = ALU_ADD;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alusrcb = SRCB_IMMSH;
        bus.aluop = ALU_ADD;
        bus.exc = EXC_EN && !legal;
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        bus.aluop = ALU_ADD;
      end
      S_MEMRD: begin
        bus.memread = 1'b1;
        bus.iord = 1'b1;
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord = 1'b1;
      end
      S_EXEC: begin
        bus.alusrca = 1'b1;
        bus.rtype = 1'b1;
      end
      S_RWB: begin
        bus.regwrite = 1'b1;
        bus.regdst = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        bus.aluop = ALU_SUB;
        bus.pcwritecond = 1'b1;
        bus.pcsource = PCS_ALUOUT;
      end
      S_JUMP: begin
        bus.pcwrite = 1'b1;
        bus.pcsource = PCS_JUMP;
      end
      S_IEXEC: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
        bus.aluop = bus.op == OP_ORI ? ALU_OR : ALU_ADD;
      end
      S_IWB: bus.regwrite = 1'b1;
      default: ;
    endcase
  end
endmodule
